// File: rtl/hb_xfer_seq.sv
// HyperBus transaction sequencer: walks one transfer through CS setup, CA, latency,
// data, CS hold and recovery, driving CS#, the CK clock-enable and datapath strobes.
module hb_xfer_seq #(
    parameter int LATENCY_CYCLES = 6,
    parameter int FIXED_LATENCY  = 0,
    parameter int CSS_CYCLES     = 1,
    parameter int CSH_CYCLES     = 1,
    parameter int RWR_CYCLES     = 4,
    parameter int LEN_WIDTH      = 16,
    parameter int RD_TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_wr,
    input  logic                 cmd_reg,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 rwds_lat,
    input  logic                 rd_word_valid,
    output logic                 hb_cs_n,
    output logic                 ck_cen,
    output logic                 ca_phase,
    output logic [1:0]           ca_idx,
    output logic                 dq_oe,
    output logic                 rwds_oe,
    output logic                 wr_data_req,
    output logic                 rd_en,
    output logic                 xfer_done,
    output logic                 xfer_err
);

    localparam int PMAX_A = (CSS_CYCLES > CSH_CYCLES) ? CSS_CYCLES : CSH_CYCLES;
    localparam int PMAX   = (PMAX_A > RWR_CYCLES) ? PMAX_A : RWR_CYCLES;
    localparam int PW     = $clog2(PMAX + 32'sd1);
    localparam int TW     = $clog2(RD_TIMEOUT + 32'sd1);
    // LAT lasts Ltot-2 cycles, never less than one.
    localparam int LAT_S  = (LATENCY_CYCLES > 32'sd3) ? LATENCY_CYCLES - 32'sd2 : 32'sd1;
    localparam int LAT_D  = (2 * LATENCY_CYCLES > 32'sd3) ? 2 * LATENCY_CYCLES - 32'sd2 : 32'sd1;

    localparam logic [3:0]           LAT_S_LAST = 4'(LAT_S - 32'sd1);
    localparam logic [3:0]           LAT_D_LAST = 4'(LAT_D - 32'sd1);
    localparam logic [PW-1:0]        CSS_LD     = PW'(CSS_CYCLES - 32'sd1);
    localparam logic [PW-1:0]        CSH_LD     = PW'(CSH_CYCLES - 32'sd1);
    localparam logic [PW-1:0]        RWR_LD     = PW'(RWR_CYCLES - 32'sd1);
    localparam logic [TW-1:0]        TMO_LIM    = TW'(RD_TIMEOUT);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(32'd1);
    localparam logic                 FIXED_DBL  = (FIXED_LATENCY != 32'sd0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CSS  = 3'd1,
        ST_CA   = 3'd2,
        ST_LAT  = 3'd3,
        ST_DATA = 3'd4,
        ST_CSH  = 3'd5,
        ST_RWR  = 3'd6
    } state_t;

    state_t               state_r, state_s;
    logic [PW-1:0]        pcnt_r, pcnt_s;
    logic [1:0]           ca_idx_r, ca_idx_s;
    logic [3:0]           lat_cnt_r, lat_cnt_s;
    logic [LEN_WIDTH-1:0] word_cnt_r, word_cnt_s;
    logic [TW-1:0]        tmo_cnt_r, tmo_cnt_s;
    logic                 wr_r, wr_s, reg_r, reg_s, err_r, err_s, lat_dbl_r, lat_dbl_s;
    logic                 cmd_ready_r, cmd_ready_s, hb_cs_n_r, hb_cs_n_s, ck_cen_r, ck_cen_s;
    logic                 ca_phase_r, ca_phase_s, dq_oe_r, dq_oe_s, rwds_oe_r, rwds_oe_s;
    logic                 wr_data_req_r, wr_data_req_s, rd_en_r, rd_en_s;
    logic                 xfer_done_r, xfer_done_s, xfer_err_r, xfer_err_s;

    // Next-state, counter and output decode; outputs are decoded from the next state
    // so that the registered outputs always describe the state being entered.
    always_comb begin
        state_s    = state_r;
        pcnt_s     = pcnt_r;
        ca_idx_s   = ca_idx_r;
        lat_cnt_s  = lat_cnt_r;
        word_cnt_s = word_cnt_r;
        tmo_cnt_s  = tmo_cnt_r;
        wr_s       = wr_r;
        reg_s      = reg_r;
        err_s      = err_r;
        lat_dbl_s  = lat_dbl_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    wr_s       = cmd_wr;
                    reg_s      = cmd_reg;
                    word_cnt_s = (cmd_len == {LEN_WIDTH{1'b0}}) ? LEN_ONE : cmd_len;
                    err_s      = 1'b0;
                    pcnt_s     = CSS_LD;
                    state_s    = ST_CSS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CSS: begin
                if (pcnt_r == {PW{1'b0}}) begin
                    ca_idx_s = 2'd0;
                    state_s  = ST_CA;
                end else begin
                    pcnt_s = pcnt_r - 1'b1;
                end
            end
            ST_CA: begin
                if (ca_idx_r == 2'd2) begin
                    ca_idx_s  = 2'd0;
                    lat_dbl_s = FIXED_DBL | rwds_lat;
                    lat_cnt_s = 4'd0;
                    tmo_cnt_s = {TW{1'b0}};
                    if (wr_r && reg_r) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_LAT;
                    end
                end else begin
                    ca_idx_s = ca_idx_r + 2'd1;
                end
            end
            ST_LAT: begin
                if (lat_cnt_r == (lat_dbl_r ? LAT_D_LAST : LAT_S_LAST)) begin
                    state_s = ST_DATA;
                end else begin
                    lat_cnt_s = lat_cnt_r + 4'd1;
                end
            end
            ST_DATA: begin
                // word_cnt holds the words still outstanding, so it never wraps.
                if (wr_r) begin
                    if (word_cnt_r == LEN_ONE) begin
                        pcnt_s  = CSH_LD;
                        state_s = ST_CSH;
                    end else begin
                        word_cnt_s = word_cnt_r - 1'b1;
                    end
                end else if (rd_word_valid) begin
                    tmo_cnt_s = {TW{1'b0}};
                    if (word_cnt_r == LEN_ONE) begin
                        pcnt_s  = CSH_LD;
                        state_s = ST_CSH;
                    end else begin
                        word_cnt_s = word_cnt_r - 1'b1;
                    end
                end else if ((tmo_cnt_r + 1'b1) == TMO_LIM) begin
                    err_s   = 1'b1;
                    pcnt_s  = CSH_LD;
                    state_s = ST_CSH;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 1'b1;
                end
            end
            ST_CSH: begin
                if (pcnt_r == {PW{1'b0}}) begin
                    pcnt_s  = RWR_LD;
                    state_s = ST_RWR;
                end else begin
                    pcnt_s = pcnt_r - 1'b1;
                end
            end
            ST_RWR: begin
                if (pcnt_r == {PW{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    pcnt_s = pcnt_r - 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        cmd_ready_s   = 1'b0;
        hb_cs_n_s     = 1'b0;
        ck_cen_s      = 1'b0;
        ca_phase_s    = 1'b0;
        dq_oe_s       = 1'b0;
        rwds_oe_s     = 1'b0;
        wr_data_req_s = 1'b0;
        rd_en_s       = 1'b0;
        xfer_done_s   = 1'b0;
        xfer_err_s    = 1'b0;

        case (state_s)
            ST_IDLE: begin
                hb_cs_n_s   = 1'b1;
                cmd_ready_s = 1'b1;
            end
            ST_CSS: begin
                hb_cs_n_s = 1'b0;
            end
            ST_CA: begin
                ck_cen_s   = 1'b1;
                ca_phase_s = 1'b1;
                dq_oe_s    = 1'b1;
            end
            ST_LAT: begin
                ck_cen_s = 1'b1;
            end
            ST_DATA: begin
                ck_cen_s = 1'b1;
                if (wr_s) begin
                    dq_oe_s       = 1'b1;
                    rwds_oe_s     = ~reg_s;
                    wr_data_req_s = 1'b1;
                end else begin
                    rd_en_s = 1'b1;
                end
            end
            ST_CSH: begin
                if (pcnt_s == {PW{1'b0}}) begin
                    xfer_done_s = 1'b1;
                    xfer_err_s  = err_s;
                end else begin
                    xfer_done_s = 1'b0;
                end
            end
            ST_RWR: begin
                hb_cs_n_s = 1'b1;
            end
            default: begin
                hb_cs_n_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; reset releases CS# immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            pcnt_r        <= {PW{1'b0}};
            ca_idx_r      <= 2'd0;
            lat_cnt_r     <= 4'd0;
            word_cnt_r    <= {LEN_WIDTH{1'b0}};
            tmo_cnt_r     <= {TW{1'b0}};
            wr_r          <= 1'b0;
            reg_r         <= 1'b0;
            err_r         <= 1'b0;
            lat_dbl_r     <= 1'b0;
            cmd_ready_r   <= 1'b0;
            hb_cs_n_r     <= 1'b1;
            ck_cen_r      <= 1'b0;
            ca_phase_r    <= 1'b0;
            dq_oe_r       <= 1'b0;
            rwds_oe_r     <= 1'b0;
            wr_data_req_r <= 1'b0;
            rd_en_r       <= 1'b0;
            xfer_done_r   <= 1'b0;
            xfer_err_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            pcnt_r        <= pcnt_s;
            ca_idx_r      <= ca_idx_s;
            lat_cnt_r     <= lat_cnt_s;
            word_cnt_r    <= word_cnt_s;
            tmo_cnt_r     <= tmo_cnt_s;
            wr_r          <= wr_s;
            reg_r         <= reg_s;
            err_r         <= err_s;
            lat_dbl_r     <= lat_dbl_s;
            cmd_ready_r   <= cmd_ready_s;
            hb_cs_n_r     <= hb_cs_n_s;
            ck_cen_r      <= ck_cen_s;
            ca_phase_r    <= ca_phase_s;
            dq_oe_r       <= dq_oe_s;
            rwds_oe_r     <= rwds_oe_s;
            wr_data_req_r <= wr_data_req_s;
            rd_en_r       <= rd_en_s;
            xfer_done_r   <= xfer_done_s;
            xfer_err_r    <= xfer_err_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign hb_cs_n     = hb_cs_n_r;
    assign ck_cen      = ck_cen_r;
    assign ca_phase    = ca_phase_r;
    assign ca_idx      = ca_idx_r;
    assign dq_oe       = dq_oe_r;
    assign rwds_oe     = rwds_oe_r;
    assign wr_data_req = wr_data_req_r;
    assign rd_en       = rd_en_r;
    assign xfer_done   = xfer_done_r;
    assign xfer_err    = xfer_err_r;

endmodule

// File: tb/tb_hb_xfer_seq.sv
// Bench for hb_xfer_seq: a transaction-level model expands each command into its
// per-cycle input/output trace; every cycle of the DUT is compared against it.
module tb_hb_xfer_seq;

    localparam int LATENCY_CYCLES = 6;
    localparam int FIXED_LATENCY  = 0;
    localparam int CSS_CYCLES     = 1;
    localparam int CSH_CYCLES     = 1;
    localparam int RWR_CYCLES     = 4;
    localparam int LEN_WIDTH      = 16;
    localparam int RD_TIMEOUT     = 64;

    logic                 clk, rstn, cmd_valid, cmd_ready, cmd_wr, cmd_reg;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 rwds_lat, rd_word_valid;
    logic                 hb_cs_n, ck_cen, ca_phase, dq_oe, rwds_oe, wr_data_req, rd_en;
    logic                 xfer_done, xfer_err;
    logic [1:0]           ca_idx;

    hb_xfer_seq #(
        .LATENCY_CYCLES(LATENCY_CYCLES), .FIXED_LATENCY(FIXED_LATENCY),
        .CSS_CYCLES(CSS_CYCLES), .CSH_CYCLES(CSH_CYCLES), .RWR_CYCLES(RWR_CYCLES),
        .LEN_WIDTH(LEN_WIDTH), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .rwds_lat(rwds_lat),
        .rd_word_valid(rd_word_valid), .hb_cs_n(hb_cs_n), .ck_cen(ck_cen),
        .ca_phase(ca_phase), .ca_idx(ca_idx), .dq_oe(dq_oe), .rwds_oe(rwds_oe),
        .wr_data_req(wr_data_req), .rd_en(rd_en), .xfer_done(xfer_done), .xfer_err(xfer_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic cv; logic wr; logic rg; logic [LEN_WIDTH-1:0] len; logic rwds; logic rdv;
    } in_t;
    typedef struct packed {
        logic cs_n; logic ck; logic ca_ph; logic [1:0] ca_idx; logic dq_oe; logic rwds_oe;
        logic wreq; logic rd_en; logic done; logic err; logic ready;
    } out_t;

    in_t  in_q[$];
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   pin_en   = 1'b0;
    int   txn_idx  = 0;

    // Hand-computed figures for the four directed transactions (defaults: L=6, CSS=CSH=1).
    int lit_ck  [4] = '{11, 15, 4, 72};
    int lit_wq  [4] = '{4, 0, 1, 0};
    int lit_lat [4] = '{4, 10, 0, 4};
    int lit_err [4] = '{0, 0, 0, 1};

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic in_t rnd_in();
        in_t v;
        v.cv   = 1'($urandom_range(0, 1));
        v.wr   = 1'($urandom_range(0, 1));
        v.rg   = 1'($urandom_range(0, 1));
        v.len  = LEN_WIDTH'($urandom_range(0, 8));
        v.rwds = 1'($urandom_range(0, 1));
        v.rdv  = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic out_t o_idle();
        out_t o = '0;
        o.cs_n = 1'b1;
        return o;
    endfunction

    function automatic out_t o_sel(input bit ck);
        out_t o = '0;
        o.ck = ck;
        return o;
    endfunction

    // Gap (idle cycles) before read word 'w'; RD_TIMEOUT or more means the word never comes.
    function automatic int gap(input int mode, input int w);
        int r;
        if (mode == 1) return 0;
        if (mode == 2) return (w == 0) ? 0 : RD_TIMEOUT;
        r = $urandom_range(0, 19);
        if (r < 12) return $urandom_range(0, 3);
        if (r < 17) return $urandom_range(4, 20);
        if (r < 19) return RD_TIMEOUT - 1;
        return RD_TIMEOUT;
    endfunction

    task automatic push(input in_t i, input out_t o);
        in_q.push_back(i);
        exp_q.push_back(o);
    endtask

    task automatic add_idle(input int n);
        in_t i; out_t o;
        for (int k = 0; k < n; k++) begin
            i = rnd_in(); i.cv = 1'b0;
            o = o_idle(); o.ready = 1'b1;
            push(i, o);
        end
    endtask

    task automatic add_txn(input bit wr, input bit rg, input int len, input int rwds_fix,
                           input int mode, input int idle_before);
        in_t i; out_t o;
        int  leff, n, g, words;
        bit  dbl, timed;
        add_idle(idle_before);
        i = rnd_in(); i.cv = 1'b1; i.wr = wr; i.rg = rg; i.len = LEN_WIDTH'(len);
        o = o_idle(); o.ready = 1'b1;
        push(i, o);
        leff  = (len == 0) ? 1 : len;
        dbl   = (FIXED_LATENCY != 0);
        timed = 1'b0;
        for (int c = 0; c < CSS_CYCLES; c++) push(rnd_in(), o_sel(1'b0));
        for (int c = 0; c < 3; c++) begin
            i = rnd_in();
            if (c == 2) begin
                if (rwds_fix >= 0) i.rwds = 1'(rwds_fix);
                dbl = dbl | i.rwds;
            end
            o = o_sel(1'b1); o.ca_ph = 1'b1; o.ca_idx = 2'(c); o.dq_oe = 1'b1;
            push(i, o);
        end
        if (!(wr && rg)) begin
            n = (dbl ? 2 * LATENCY_CYCLES : LATENCY_CYCLES) - 2;
            if (n < 1) n = 1;
            for (int c = 0; c < n; c++) push(rnd_in(), o_sel(1'b1));
        end
        if (wr) begin
            for (int c = 0; c < leff; c++) begin
                o = o_sel(1'b1); o.dq_oe = 1'b1; o.rwds_oe = !rg; o.wreq = 1'b1;
                push(rnd_in(), o);
            end
        end else begin
            words = 0;
            while (words < leff && !timed) begin
                g = gap(mode, words);
                for (int z = 0; z < g && z < RD_TIMEOUT; z++) begin
                    i = rnd_in(); i.rdv = 1'b0;
                    o = o_sel(1'b1); o.rd_en = 1'b1;
                    push(i, o);
                end
                if (g >= RD_TIMEOUT) begin
                    timed = 1'b1;
                end else begin
                    i = rnd_in(); i.rdv = 1'b1;
                    o = o_sel(1'b1); o.rd_en = 1'b1;
                    push(i, o);
                    words++;
                end
            end
        end
        for (int c = 0; c < CSH_CYCLES; c++) begin
            o = o_sel(1'b0);
            if (c == CSH_CYCLES - 1) begin o.done = 1'b1; o.err = timed; end
            push(rnd_in(), o);
        end
        for (int c = 0; c < RWR_CYCLES; c++) push(rnd_in(), o_idle());
    endtask

    // Replays the planned trace: compare this cycle's outputs, then drive this cycle's inputs.
    task automatic run_plan();
        out_t act, e;
        int   ck_c = 0, wq_c = 0, lat_c = 0, rwr_c = 0;
        bit   after_done = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            act.cs_n = hb_cs_n; act.ck = ck_cen; act.ca_ph = ca_phase; act.ca_idx = ca_idx;
            act.dq_oe = dq_oe; act.rwds_oe = rwds_oe; act.wreq = wr_data_req; act.rd_en = rd_en;
            act.done = xfer_done; act.err = xfer_err; act.ready = cmd_ready;
            e = exp_q[k];
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL out_vec cyc %0d: got %b expected %b", k, act, e);
            end
            if (act.ck) ck_c++;
            if (act.wreq) wq_c++;
            if (act.ck && !act.ca_ph && !act.dq_oe && !act.rd_en) lat_c++;
            if (after_done) begin
                if (e.ready) begin
                    chk("rwr_to_ready", rwr_c, RWR_CYCLES);
                    after_done = 1'b0;
                end else if (act.cs_n && !act.ready) begin
                    rwr_c++;
                end
            end
            if (e.done) begin
                if (pin_en && txn_idx < 4) begin
                    chk("pin_ck_cycles", ck_c, lit_ck[txn_idx]);
                    chk("pin_wreq_cycles", wq_c, lit_wq[txn_idx]);
                    chk("pin_lat_cycles", lat_c, lit_lat[txn_idx]);
                    chk("pin_err", int'(act.err), lit_err[txn_idx]);
                end
                txn_idx++;
                ck_c = 0; wq_c = 0; lat_c = 0; rwr_c = 0;
                after_done = 1'b1;
            end
            cmd_valid     = in_q[k].cv;
            cmd_wr        = in_q[k].wr;
            cmd_reg       = in_q[k].rg;
            cmd_len       = in_q[k].len;
            rwds_lat      = in_q[k].rwds;
            rd_word_valid = in_q[k].rdv;
        end
        cmd_valid = 1'b0;
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit seen;
        rstn = 1'b0; cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_reg = 1'b0;
        cmd_len = LEN_WIDTH'(4); rwds_lat = 1'b0; rd_word_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", int'(hb_cs_n), 1);
        chk("rst_ck_cen", int'(ck_cen), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        cmd_valid = 1'b0; rd_word_valid = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("ready_first_edge", int'(cmd_ready), 1);

        pin_en = 1'b1;
        add_txn(1'b1, 1'b0, 4, 0, 1, 0);
        add_txn(1'b0, 1'b0, 2, 1, 1, 2);
        add_txn(1'b1, 1'b1, 1, -1, 1, 1);
        add_txn(1'b0, 1'b0, 3, 0, 2, 0);
        for (int t = 0; t < 20; t++)
            add_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), -1, 0, $urandom_range(0, 3));
        add_idle(2);
        run_plan();
        pin_en = 1'b0;

        // Abort a write in the middle of its data phase.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_reg = 1'b0; cmd_len = LEN_WIDTH'(8);
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (wr_data_req) seen = 1'b1;
        end
        chk("mid_wreq_seen", int'(seen), 1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_cs_n", int'(hb_cs_n), 1);
        chk("mid_rst_ck_cen", int'(ck_cen), 0);
        chk("mid_rst_wreq", int'(wr_data_req), 0);
        @(negedge clk);
        rstn = 1'b1;

        add_txn(1'b1, 1'b0, 3, -1, 0, 0);
        for (int t = 0; t < 4; t++)
            add_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 5), -1, 0, $urandom_range(0, 2));
        add_idle(2);
        run_plan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hb_xfer_seq.md
# hb_xfer_seq

HyperBus transaction sequencer that drives the chip-select and the `cen` clock-enable input of the HyperBus clock output buffer. It walks one transaction at a time through CS setup, command-address (CA), initial latency, data, CS hold and read-write recovery. It sits between the command front-end and the DQ/RWDS/CK I/O primitives. Its outputs tell the datapath which phase is active and when to supply or expect 16-bit words.

## Interface
Parameters:
- LATENCY_CYCLES, 6, base initial latency in CK cycles; legal 3..7
- FIXED_LATENCY, 0, 1 = always double latency (ignore `rwds_lat`)
- CSS_CYCLES, 1, CS#-low-to-first-CK setup cycles; legal ≥1
- CSH_CYCLES, 1, last-CK-to-CS#-high hold cycles; legal ≥1
- RWR_CYCLES, 4, CS#-high recovery cycles before next command; legal ≥1
- LEN_WIDTH, 16, width of `cmd_len`
- RD_TIMEOUT, 64, maximum clk cycles between read words before abort

Ports:
- clk  in  1  controller clock, same clock as the CK output buffer
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with `cmd_valid`
- cmd_wr  in  1  1 = write, 0 = read
- cmd_reg  in  1  register-space access; a register write skips latency
- cmd_len  in  LEN_WIDTH  transfer length in 16-bit words; 0 is treated as 1
- rwds_lat  in  1  RWDS level sampled by the I/O during CA
- rd_word_valid  in  1  one read word captured by the read datapath
- hb_cs_n  out  1  HyperBus CS#
- ck_cen  out  1  to the clock buffer `cen`; 1 = toggle CK this cycle
- ca_phase  out  1  CA words on DQ
- ca_idx  out  2  CA word index, 0..2
- dq_oe  out  1  DQ output enable, asserted during CA and write data
- rwds_oe  out  1  RWDS drive enable, asserted during the write data phase
- wr_data_req  out  1  upstream must present the next write word this cycle
- rd_en  out  1  read capture window open
- xfer_done  out  1  one-cycle pulse at transaction end
- xfer_err  out  1  one-cycle pulse at the same time as `xfer_done` when a read times out

## Operation
- All outputs are registered.
- Reset values: hb_cs_n=1, all other outputs 0, including `cmd_ready`.
- Asserting `rstn` in any state aborts immediately: CS# goes high asynchronously and the FSM enters IDLE.

FSM states: IDLE, CSS, CA, LAT, DATA, CSH, RWR.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch `cmd_wr`, `cmd_reg` and `cmd_len` (0→1), drop `cmd_ready`, and go to CSS.
- **CSS:**
  - hb_cs_n=0, ck_cen=0, held for CSS_CYCLES.
  - Then go to CA.
- **CA:**
  - 3 cycles with ck_cen=1, ca_phase=1, dq_oe=1; `ca_idx` runs 0,1,2.
  - Register `rwds_lat` in the `ca_idx`=2 cycle.
  - Register write: go directly to DATA. Otherwise go to LAT.
- **LAT:**
  - ck_cen=1, dq_oe=0.
  - Duration = Ltot−2 cycles, where Ltot = LATENCY_CYCLES × 2 if (FIXED_LATENCY | rwds_lat), else LATENCY_CYCLES × 1.
  - Minimum duration is 1 cycle.
- **DATA, write:**
  - ck_cen=1, dq_oe=1, rwds_oe=1 (rwds_oe stays 0 for register writes), wr_data_req=1.
  - Lasts exactly `cmd_len` cycles. There is no backpressure.
- **DATA, read:**
  - ck_cen=1, rd_en=1.
  - Count `rd_word_valid` pulses. Leave when the count equals `cmd_len`.
  - An idle counter resets on every word. When it reaches RD_TIMEOUT, leave and flag the error.
- **CSH:**
  - ck_cen=0, rd_en=0, hb_cs_n=0, held for CSH_CYCLES.
  - On the last cycle, pulse `xfer_done` (and `xfer_err` if the read timed out).
- **RWR:**
  - hb_cs_n=1, held for RWR_CYCLES.
  - Then go to IDLE; `cmd_ready` rises on entry to IDLE.

Boundary rules:
- `rd_word_valid` outside DATA is ignored.
- Extra read words beyond `cmd_len` are ignored.
- `cmd_valid` outside IDLE has no effect.

## Timing
- Accept edge → hb_cs_n low on the next edge.
- First ck_cen=1 comes CSS_CYCLES later.
- CK pulses appear one cycle after `ck_cen` because of the clock-buffer output register. The DQ/RWDS output registers use the same one-cycle delay.
- Write transaction, total cycles from accept to IDLE = 1 + CSS + 3 + (Ltot−2) + len + CSH + RWR.
- Register write omits the (Ltot−2) term.
- Back-to-back commands: minimum CS#-high time is RWR_CYCLES. The next accept happens no earlier than the first IDLE cycle.
- Counter widths:
  - latency counter 4 bits
  - word counter LEN_WIDTH bits
  - timeout counter ceil(log2(RD_TIMEOUT+1)) bits
  - no wrap is permitted

## Test plan
- **Reset:** hold rstn=0 with cmd_valid=1 → hb_cs_n=1, ck_cen=0, cmd_ready=0. After release, cmd_ready=1 on the first edge.
- **Memory write, len=4, rwds_lat=0, defaults:**
  - ck_cen high for 3+4+4 = 11 cycles
  - wr_data_req high for exactly 4 cycles
  - xfer_done after 1 CSH cycle
  - cmd_ready back 4 cycles after CS# rises
- **Read, len=2, rwds_lat=1:** LAT lasts 10 cycles. Feed 2 rd_word_valid pulses → ck_cen drops the cycle after the second word, xfer_done=1, xfer_err=0.
- **Register write, len=1:** no LAT state, rwds_oe=0, ck_cen high for 4 cycles.
- **Read, len=3, only 1 word delivered:** after 64 idle cycles, xfer_done=1 and xfer_err=1, hb_cs_n returns high, the FSM returns to IDLE.
- **Reset pulled mid-DATA:** hb_cs_n=1 immediately (asynchronous), ck_cen=0. The next command runs normally.
